fpu_issue_sequencer: RTL and testbench

- Front-end stage that sits directly upstream of pipelined_fpu and drives its op/start/operand_a/operand_b inputs.
- Buffers requests from the core in a DEPTH-entry FIFO with a valid/ready interface.
- Issues one operation at a time, honouring the FPU's busy/done handshake.
- Returns each result with the requester's tag through a single-entry valid/ready response register.

---
 rtl/fpu_issue_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fpu_issue_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sequencer.sv
// Request FIFO plus one-at-a-time issue FSM in front of pipelined_fpu, with a tagged response register.
// Optional WAIT-state watchdog is built only when FPU_SEQ_TIMEOUT_EN is defined.
module fpu_issue_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic [TAG_W-1:0]         req_tag,
  output logic [2:0]               fpu_op,
  output logic                     fpu_start,
  output logic [31:0]              fpu_operand_a,
  output logic [31:0]              fpu_operand_b,
  input  logic                     fpu_busy,
  input  logic                     fpu_done,
  input  logic [31:0]              fpu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [2:0]       op_mem  [DEPTH];
  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [TAG_W-1:0] issue_tag;
  logic             push, pop, capture, to_hit, to_fire;

  assign req_ready = (fifo_count != FULL);
  assign push      = req_valid && req_ready;
  assign fpu_start = (state == S_ISSUE);

  // FIFO storage carries data only; occupancy and pointers are the control state
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= req_op;
      a_mem[wr_ptr]   <= req_a;
      b_mem[wr_ptr]   <= req_b;
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    to_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        // A new issue is held off while an unaccepted response would be overwritten
        if (fifo_count != '0 && !fpu_busy && (!rsp_valid || rsp_ready)) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fpu_done) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_done) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue registers hold the last issued request between operations
  always_ff @(posedge clk) begin
    if (reset) begin
      fpu_op        <= '0;
      fpu_operand_a <= '0;
      fpu_operand_b <= '0;
      issue_tag     <= '0;
    end else if (pop) begin
      fpu_op        <= op_mem[rd_ptr];
      fpu_operand_a <= a_mem[rd_ptr];
      fpu_operand_b <= b_mem[rd_ptr];
      issue_tag     <= tag_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else if (capture || to_fire) begin
      rsp_valid  <= 1'b1;
      rsp_result <= to_fire ? QNAN : fpu_result;
      rsp_tag    <= issue_tag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counter is zero on the first WAIT cycle; it fires on the last allowed WAIT cycle
  always_ff @(posedge clk) begin
    if (reset)                  wd_cnt <= '0;
    else if (state == S_ISSUE)  wd_cnt <= '0;
    else if (state == S_WAIT)   wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign to_hit = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)        rsp_timeout <= 1'b0;
    else if (capture) rsp_timeout <= 1'b0;
    else if (to_fire) rsp_timeout <= 1'b1;
  end
`else
  assign to_hit      = (TIMEOUT_CYCLES < 0);
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer with an XOR FPU stub and a response scoreboard.
// Build with FPU_SEQ_TIMEOUT_EN defined to also cover the watchdog path.
module tb_fpu_issue_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       fpu_op;
  logic             fpu_start;
  logic [31:0]      fpu_operand_a, fpu_operand_b;
  logic             fpu_busy, fpu_done;
  logic [31:0]      fpu_result;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic [2:0]       fifo_count;

  fpu_issue_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_busy(fpu_busy), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // FPU stub: result = a ^ b, done d_lat cycles after start, busy while computing
  int          d_lat = 0;
  logic        never_done = 1'b0;
  logic        force_busy = 1'b0;
  logic        pend = 1'b0;
  int          rem = 0;
  logic [31:0] held = '0;

  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (fpu_start && d_lat != 0) begin
      pend <= 1'b1;
      rem  <= d_lat - 1;
      held <= fpu_operand_a ^ fpu_operand_b;
    end else if (pend) begin
      if (rem == 0) pend <= 1'b0;
      else          rem  <= rem - 1;
    end
  end

  assign fpu_done   = !never_done && ((fpu_start && d_lat == 0) || (pend && rem == 0));
  assign fpu_result = fpu_start ? (fpu_operand_a ^ fpu_operand_b) : held;
  assign fpu_busy   = force_busy || pend;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  int   last_rsp = -1000;
  logic gap_chk = 1'b0;
  logic exp_to = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluates both handshakes with the inputs driven for the current cycle
  task automatic mon();
    exp_t e;
    if (req_valid && req_ready) begin
      e.res = exp_to ? 32'h7FC0_0000 : (req_a ^ req_b);
      e.tag = req_tag;
      e.to  = exp_to;
      sb.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
      if (gap_chk) chk("rsp_gap_ge7", 32'(cyc_n - last_rsp >= 7), 32'd1);
      last_rsp = cyc_n;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_req(input logic [TAG_W-1:0] t);
    req_valid = 1'b1;
    req_op    = 3'(t);
    req_a     = 32'h1234_0000 | 32'(t);
    req_b     = 32'h00A5_5A00 ^ {32'(t), 4'h0};
    req_tag   = t;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) cyc();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cyc(); cyc();

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_operand_a", fpu_operand_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    reset = 1'b0;
    cyc();

    // Single-cycle op latency
    d_lat = 0;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_tag = 4'd3;
    cyc();
    req_valid = 1'b0;
    chk("t1_start_t1", 32'(fpu_start), 32'd0);
    chk("t1_count_t1", 32'(fifo_count), 32'd1);
    cyc();
    chk("t1_start_t2", 32'(fpu_start), 32'd1);
    chk("t1_rspv_t2", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t1_start_t3", 32'(fpu_start), 32'd0);
    chk("t1_rspv_t3", 32'(rsp_valid), 32'd1);
    chk("t1_result", rsp_result, 32'h7F80_0000);
    chk("t1_tag", 32'(rsp_tag), 32'd3);
    cyc();
    chk("t1_rspv_t4", 32'(rsp_valid), 32'd0);

    // Fill the FIFO while the FPU reports busy, then stall a 5th request
    d_lat = 5; force_busy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(4'(t));
      cyc();
    end
    chk("t2_count_full", 32'(fifo_count), 32'd4);
    chk("t2_ready_full", 32'(req_ready), 32'd0);
    set_req(4'd4);
    cyc();
    chk("t2_count_stall", 32'(fifo_count), 32'd4);
    force_busy = 1'b0;
    chk("t3_pop_cycle_count", 32'(fifo_count), 32'd4);
    chk("t3_pop_cycle_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("t3_after_pop_count", 32'(fifo_count), 32'd3);
    chk("t3_after_pop_start", 32'(fpu_start), 32'd1);
    cyc();
    req_valid = 1'b0;
    chk("t3_refill_count", 32'(fifo_count), 32'd4);
    gap_chk = 1'b1; last_rsp = -1000;
    drain("t2_drain");
    gap_chk = 1'b0;
    chk("t2_count_empty", 32'(fifo_count), 32'd0);

    // Response back-pressure holds the first result and blocks further issue
    d_lat = 0; rsp_ready = 1'b0;
    for (int t = 5; t < 8; t++) begin
      set_req(4'(t));
      cyc();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_tag", 32'(rsp_tag), 32'd5);
      chk("t4_hold_result", rsp_result, (32'h1234_0000 | 32'd5) ^ (32'h00A5_5A00 ^ 32'h50));
      chk("t4_no_start", 32'(fpu_start), 32'd0);
      chk("t4_count", 32'(fifo_count), 32'd2);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    chk("t4_start_after_accept", 32'(fpu_start), 32'd1);
    drain("t4_drain");

    // Busy FPU blocks issue; reset during WAIT flushes everything
    d_lat = 3; force_busy = 1'b1;
    set_req(4'd8); cyc();
    set_req(4'd9); cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_busy_no_start", 32'(fpu_start), 32'd0);
      cyc();
    end
    chk("t5_busy_count", 32'(fifo_count), 32'd2);
    force_busy = 1'b0;
    cyc();
    chk("t5_start", 32'(fpu_start), 32'd1);
    cyc();
    chk("t5_wait_no_start", 32'(fpu_start), 32'd0);
    reset = 1'b1;
    sb.delete();
    cyc();
    reset = 1'b0;
    chk("t5_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_abandoned", 32'(rsp_valid | fpu_start), 32'd0);
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    // Watchdog: no done ever arrives
    d_lat = 2; never_done = 1'b1; exp_to = 1'b1;
    set_req(4'd10);
    cyc();
    req_valid = 1'b0; exp_to = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    chk("t6_rspv_early", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t6_rspv", 32'(rsp_valid), 32'd1);
    chk("t6_result", rsp_result, 32'h7FC0_0000);
    chk("t6_timeout", 32'(rsp_timeout), 32'd1);
    cyc();
    never_done = 1'b0;
    set_req(4'd11);
    cyc();
    req_valid = 1'b0;
    drain("t6_drain");
    chk("t6_timeout_clear", 32'(rsp_timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
